// File: rtl/rice_core_writeback_arbiter_if.sv
// Writeback request/port bundle shared between result producers, the
// arbiter and the register-file write port.
interface rice_core_writeback_arbiter_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned RD_WIDTH = 5
);
    localparam int unsigned GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]          i_req_valid;
    logic [N_REQ-1:0]          o_req_ready;
    logic [N_REQ*RD_WIDTH-1:0] i_req_rd;
    logic [N_REQ*XLEN-1:0]     i_req_value;
    logic                      o_wb_valid;
    logic [RD_WIDTH-1:0]       o_wb_rd;
    logic [XLEN-1:0]           o_wb_value;
    logic [31:0]               o_pending;
    logic [GID_W-1:0]          o_grant_id;

    // Arbiter side.
    modport slave (
        input  i_req_valid, i_req_rd, i_req_value,
        output o_req_ready, o_wb_valid, o_wb_rd, o_wb_value, o_pending, o_grant_id
    );

    // Producer / register-file side.
    modport master (
        output i_req_valid, i_req_rd, i_req_value,
        input  o_req_ready, o_wb_valid, o_wb_rd, o_wb_value, o_pending, o_grant_id
    );
endinterface

// File: rtl/rice_core_writeback_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// N_REQ result producers. One grant per cycle, registered output stage,
// x0 writes absorbed, pending-destination bitmap exported for hazard logic.
module rice_core_writeback_arbiter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned RD_WIDTH = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    rice_core_writeback_arbiter_if.slave bus
);
    localparam int unsigned GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [GID_W-1:0]    last_q, last_d;
    logic [GID_W-1:0]    gid_q, gid_d;
    logic                wb_valid_q, wb_valid_d;
    logic [RD_WIDTH-1:0] rd_q, rd_d;
    logic [XLEN-1:0]     value_q, value_d;

    logic [N_REQ-1:0]    elig;
    logic [N_REQ-1:0]    x0_req;
    logic [N_REQ-1:0]    masked;
    logic [N_REQ-1:0]    search;
    logic [N_REQ-1:0]    onehot;
    logic                found;
    logic                grant;
    logic [GID_W-1:0]    win;
    logic [RD_WIDTH-1:0] win_rd;
    logic [XLEN-1:0]     win_value;
    logic [31:0]         pending;

    // Classify each request as eligible (nonzero rd) or an x0 discard.
    always_comb begin
        elig   = '0;
        x0_req = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            elig[k]   = bus.i_req_valid[k] && (bus.i_req_rd[k*RD_WIDTH +: RD_WIDTH] != '0);
            x0_req[k] = bus.i_req_valid[k] && (bus.i_req_rd[k*RD_WIDTH +: RD_WIDTH] == '0);
        end
    end

    // Round-robin pick: lowest eligible index above last_q, else wrap to the lowest overall.
    always_comb begin
        masked    = '0;
        onehot    = '0;
        found     = 1'b0;
        win       = '0;
        win_rd    = '0;
        win_value = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            masked[k] = elig[k] && (k > 32'(last_q));
        end
        search = (masked != '0) ? masked : elig;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && search[k]) begin
                found     = 1'b1;
                onehot[k] = 1'b1;
                win       = GID_W'(k);
                win_rd    = bus.i_req_rd[k*RD_WIDTH +: RD_WIDTH];
                win_value = bus.i_req_value[k*XLEN +: XLEN];
            end
        end
        // No grants while reset is held; x0 discards are still acknowledged.
        grant = found && !i_rst;
    end

    // Ready: every x0 request plus the single winner.
    assign bus.o_req_ready = x0_req | (grant ? onehot : '0);

    // Output-stage and pointer next state; hold payload when nothing is granted.
    always_comb begin
        wb_valid_d = grant;
        rd_d       = rd_q;
        value_d    = value_q;
        gid_d      = gid_q;
        last_d     = last_q;
        if (grant) begin
            rd_d    = win_rd;
            value_d = win_value;
            gid_d   = win;
            last_d  = win;
        end
    end

    // State registers with asynchronous reset; pointer resets so requester 0 leads.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wb_valid_q <= 1'b0;
            rd_q       <= '0;
            value_q    <= '0;
            gid_q      <= '0;
            last_q     <= GID_W'(N_REQ - 1);
        end else begin
            wb_valid_q <= wb_valid_d;
            rd_q       <= rd_d;
            value_q    <= value_d;
            gid_q      <= gid_d;
            last_q     <= last_d;
        end
    end

    // Pending bitmap decoded from the registered output stage.
    always_comb begin
        pending = '0;
        if (wb_valid_q) begin
            pending[rd_q] = 1'b1;
        end
    end

    assign bus.o_wb_valid = wb_valid_q;
    assign bus.o_wb_rd    = rd_q;
    assign bus.o_wb_value = value_q;
    assign bus.o_grant_id = gid_q;
    assign bus.o_pending  = pending;
endmodule

// File: tb/tb_rice_core_writeback_arbiter.sv
// Bench for rice_core_writeback_arbiter: directed vector table and corner
// sequences on a 2-requester instance, fairness and randomized traffic
// against a distance-based round-robin model on a 3-requester instance.
module tb_rice_core_writeback_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rice_core_writeback_arbiter_if #(.XLEN(32), .N_REQ(2), .RD_WIDTH(5)) ifa ();
    rice_core_writeback_arbiter_if #(.XLEN(32), .N_REQ(3), .RD_WIDTH(5)) ifb ();

    rice_core_writeback_arbiter #(.XLEN(32), .N_REQ(2), .RD_WIDTH(5)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .bus(ifa)
    );
    rice_core_writeback_arbiter #(.XLEN(32), .N_REQ(3), .RD_WIDTH(5)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .bus(ifb)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive2(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1,
                          input logic [31:0] d0, input logic [31:0] d1);
        ifa.i_req_valid = v;
        ifa.i_req_rd    = {r1, r0};
        ifa.i_req_value = {d1, d0};
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  rd0, rd1;
        logic [31:0] v0, v1;
        logic [1:0]  e_ready;
        logic        e_wbv;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic        e_gid;
        logic [31:0] e_pend;
    } vec_t;

    vec_t tbl[12];

    // Random-phase requester state and reference model for the 3-way instance.
    logic        pv[3];
    logic [4:0]  prd[3];
    logic [31:0] pval[3];
    int          pwait[3];
    int          m_last;
    logic        m_wbv;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    int          m_gid;
    int          gcount[3];

    task automatic drive3();
        ifb.i_req_valid = {pv[2], pv[1], pv[0]};
        ifb.i_req_rd    = {prd[2], prd[1], prd[0]};
        ifb.i_req_value = {pval[2], pval[1], pval[0]};
    endtask

    initial begin
        //           valid  rd0    rd1    v0            v1            rdy    wbv   rd     value         gid   pending
        tbl[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b01, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h20};
        tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[2]  = '{2'b11, 5'd3, 5'd4, 32'h33,       32'h44,       2'b10, 1'b1, 5'd4, 32'h44,       1'b1, 32'h10};
        tbl[3]  = '{2'b01, 5'd3, 5'd0, 32'h33,       32'h0,        2'b01, 1'b1, 5'd3, 32'h33,       1'b0, 32'h8};
        tbl[4]  = '{2'b11, 5'd0, 5'd7, 32'h100,      32'h77,       2'b11, 1'b1, 5'd7, 32'h77,       1'b1, 32'h80};
        tbl[5]  = '{2'b01, 5'd0, 5'd0, 32'h55,       32'h0,        2'b01, 1'b0, 5'd7, 32'h77,       1'b1, 32'h0};
        tbl[6]  = '{2'b11, 5'd9, 5'd9, 32'h1,        32'h2,        2'b01, 1'b1, 5'd9, 32'h1,        1'b0, 32'h200};
        tbl[7]  = '{2'b10, 5'd0, 5'd9, 32'h0,        32'h2,        2'b10, 1'b1, 5'd9, 32'h2,        1'b1, 32'h200};
        tbl[8]  = '{2'b11, 5'd1, 5'd2, 32'hA,        32'hB,        2'b01, 1'b1, 5'd1, 32'hA,        1'b0, 32'h2};
        tbl[9]  = '{2'b11, 5'd6, 5'd2, 32'hC,        32'hB,        2'b10, 1'b1, 5'd2, 32'hB,        1'b1, 32'h4};
        tbl[10] = '{2'b11, 5'd6, 5'd8, 32'hC,        32'hD,        2'b01, 1'b1, 5'd6, 32'hC,        1'b0, 32'h40};
        tbl[11] = '{2'b10, 5'd0, 5'd8, 32'h0,        32'hD,        2'b10, 1'b1, 5'd8, 32'hD,        1'b1, 32'h100};

        rst = 1'b1;
        drive2(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0; prd[k] = '0; pval[k] = '0; pwait[k] = 0; gcount[k] = 0;
        end
        drive3();
        #12;
        chk("rst_wb_valid", ifa.o_wb_valid, 0);
        chk("rst_wb_rd",    ifa.o_wb_rd, 0);
        chk("rst_wb_value", ifa.o_wb_value, 0);
        chk("rst_grant_id", ifa.o_grant_id, 0);
        chk("rst_pending",  ifa.o_pending, 0);
        chk("rst3_wb_valid", ifb.o_wb_valid, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed vectors, one cycle each, pointer starts at N_REQ-1.
        for (int i = 0; i < 12; i++) begin
            drive2(tbl[i].valid, tbl[i].rd0, tbl[i].rd1, tbl[i].v0, tbl[i].v1);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), ifa.o_req_ready, tbl[i].e_ready);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_wb_valid", i), ifa.o_wb_valid, tbl[i].e_wbv);
            chk($sformatf("tbl%0d_wb_rd", i),    ifa.o_wb_rd, tbl[i].e_rd);
            chk($sformatf("tbl%0d_wb_value", i), ifa.o_wb_value, tbl[i].e_val);
            chk($sformatf("tbl%0d_grant_id", i), ifa.o_grant_id, tbl[i].e_gid);
            chk($sformatf("tbl%0d_pending", i),  ifa.o_pending, tbl[i].e_pend);
        end

        // Contention with valid held until accepted (pointer is 1 here).
        drive2(2'b11, 5'd3, 5'd4, 32'h3, 32'h4);
        @(negedge clk); chk("cont_ready0", ifa.o_req_ready, 2'b01);
        @(posedge clk); #1;
        chk("cont_wb_rd0", ifa.o_wb_rd, 3);
        drive2(2'b10, 5'd3, 5'd4, 32'h3, 32'h4);
        @(negedge clk); chk("cont_ready1", ifa.o_req_ready, 2'b10);
        @(posedge clk); #1;
        chk("cont_wb_rd1", ifa.o_wb_rd, 4);
        chk("cont_gid1",   ifa.o_grant_id, 1);
        drive2(2'b11, 5'd3, 5'd4, 32'h3, 32'h4);
        @(negedge clk); chk("cont_pair_again", ifa.o_req_ready, 2'b01);
        @(posedge clk); #1;
        chk("cont_wb_valid", ifa.o_wb_valid, 1);

        // Reset while a write sits in the output stage.
        drive2(2'b11, 5'd0, 5'd4, 32'h3, 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("midrst_wb_valid", ifa.o_wb_valid, 0);
        chk("midrst_pending",  ifa.o_pending, 0);
        chk("midrst_ready",    ifa.o_req_ready, 2'b01);
        @(posedge clk); #1 rst = 1'b0;
        drive2(2'b11, 5'd3, 5'd4, 32'h3, 32'h4);
        @(negedge clk); chk("postrst_ready", ifa.o_req_ready, 2'b01);
        @(posedge clk); #1;
        chk("postrst_wb_rd",  ifa.o_wb_rd, 3);
        chk("postrst_gid",    ifa.o_grant_id, 0);
        drive2(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

        // Fairness on the 3-way instance: all continuously eligible.
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b1; prd[k] = 5'(k + 10); pval[k] = 32'(k);
        end
        drive3();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("fair%0d_ready", i), ifb.o_req_ready, 3'b001 << (i % 3));
            @(posedge clk); #1;
            chk($sformatf("fair%0d_gid", i), ifb.o_grant_id, i % 3);
            if (ifb.o_wb_valid && ifb.o_grant_id < 3) gcount[ifb.o_grant_id]++;
        end
        for (int k = 0; k < 3; k++) chk($sformatf("fair_count%0d", k), gcount[k], 3);

        // Randomized traffic against the model, starting from a fresh reset.
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0; pwait[k] = 0;
        end
        drive3();
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_last = 2; m_wbv = 1'b0; m_rd = '0; m_val = '0; m_gid = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [2:0] e_ready;
            logic [2:0] got;
            int best;
            int bestd;
            for (int k = 0; k < 3; k++) begin
                if (!pv[k] && $urandom_range(0, 99) < 60) begin
                    pv[k]   = 1'b1;
                    prd[k]  = ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    pval[k] = $urandom;
                end
            end
            drive3();
            // Winner: eligible requester with the smallest rotational distance past m_last.
            best = -1; bestd = 99;
            e_ready = '0;
            for (int k = 0; k < 3; k++) begin
                if (pv[k] && prd[k] == 0) e_ready[k] = 1'b1;
                if (pv[k] && prd[k] != 0) begin
                    int d;
                    d = (k - m_last - 1 + 6) % 3;
                    if (d < bestd) begin best = k; bestd = d; end
                end
            end
            if (best >= 0) e_ready[best] = 1'b1;
            @(negedge clk);
            got = ifb.o_req_ready;
            chk("rand_ready", got, e_ready);
            for (int k = 0; k < 3; k++) begin
                if (pv[k] && prd[k] != 0) begin
                    if (got[k]) chk("rand_wait_bound", pwait[k] <= 2, 1);
                    else pwait[k]++;
                end
            end
            @(posedge clk); #1;
            if (best >= 0) begin
                m_wbv = 1'b1; m_rd = prd[best]; m_val = pval[best]; m_gid = best; m_last = best;
            end else begin
                m_wbv = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                if (pv[k] && got[k]) begin pv[k] = 1'b0; pwait[k] = 0; end
            end
            chk("rand_wb_valid", ifb.o_wb_valid, m_wbv);
            chk("rand_wb_rd",    ifb.o_wb_rd, m_rd);
            chk("rand_wb_value", ifb.o_wb_value, m_val);
            chk("rand_grant_id", ifb.o_grant_id, m_gid);
            chk("rand_pending",  ifb.o_pending, m_wbv ? (32'd1 << m_rd) : 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rice_core_writeback_arbiter.md
Name: rice_core_writeback_arbiter

Overview:
- Shares the single register-file write port between N result producers: EX pipeline, load unit, mul/div unit, and so on.
- Each requester presents a ready/valid writeback request. The block grants at most one request per cycle using round-robin priority.
- The granted result is registered and driven to the register-file write port one cycle later.
- Writes to x0 are absorbed and never reach the port. A pending-destination bitmap is exported for hazard/stall logic.

Parameters:
- XLEN, 32, data width of a register value.
- N_REQ, 2, number of requesters; legal range 1..8.
- RD_WIDTH, 5, width of a destination register index (32 architectural registers).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous and active-high.
- i_req_valid  input  N_REQ  per-requester writeback request valid.
- o_req_ready  output  N_REQ  per-requester accept, combinational from the current-cycle inputs and state.
- i_req_rd  input  N_REQ*RD_WIDTH  destination index; requester k occupies bits [k*RD_WIDTH +: RD_WIDTH].
- i_req_value  input  N_REQ*XLEN  result value; requester k occupies bits [k*XLEN +: XLEN].
- o_wb_valid  output  1  register-file write enable.
- o_wb_rd  output  RD_WIDTH  register-file write index.
- o_wb_value  output  XLEN  register-file write data.
- o_pending  output  32  bit r set while a write to register r is held in the output stage.
- o_grant_id  output  $clog2(N_REQ) (minimum 1)  index of the requester whose result is in the output stage.

Behaviour:
- Reset (asynchronous, active-high):
  - o_wb_valid=0, o_wb_rd=0, o_wb_value=0, o_grant_id=0, o_pending=0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 has top priority after reset.
- Handshake:
  - A request transfers when valid and ready are both 1 in the same cycle.
  - A requester holds valid, rd and value stable until it is accepted. Ready is never a precondition for raising valid.
- Eligibility: request k is eligible when i_req_valid[k]=1 and its rd is nonzero.
- x0 requests:
  - Every valid request with rd==0 gets ready=1 in the same cycle and is discarded.
  - Such requests never consume a grant, never move the pointer, and never set o_pending.
  - Any number of x0 requests may be accepted in one cycle.
- Arbitration:
  - Search order is (last_grant+1) mod N_REQ upward, with wrap-around.
  - The first eligible requester is granted and receives ready=1. All other eligible requesters see ready=0.
  - On a grant, last_grant becomes the granted index. With no grant, last_grant holds.
- Output stage: the register-file write port is never back-pressured, so the block grants every cycle it has an eligible request.
- Latency: a request granted in cycle t appears on o_wb_valid/o_wb_rd/o_wb_value in cycle t+1.
  - On a grant: o_wb_valid=1, o_wb_rd/o_wb_value/o_grant_id load from the winner.
  - Otherwise: o_wb_valid=0, and o_wb_rd/o_wb_value/o_grant_id hold their previous values.
- Throughput: one write per cycle, with back-to-back grants allowed.
- Fairness:
  - With all N_REQ requesters continuously eligible, grants rotate 0,1,..,N_REQ-1.
  - No requester waits more than N_REQ-1 cycles after becoming eligible.
- Same-rd conflicts:
  - Two requesters with the same rd are serialised in grant order, and the later grant's value is the final register content.
  - The block does not reorder results within one requester.
- o_pending:
  - o_pending[r] = o_wb_valid && (o_wb_rd==r), taken from registered state.
  - Bit 0 is always 0, and at most one bit is set at a time.
- N_REQ=1: the pointer logic degenerates. The single requester is granted whenever eligible, and o_grant_id stays 0.
- Reset mid-operation:
  - An in-flight output-stage write is dropped: o_wb_valid falls asynchronously on i_rst.
  - Requests present during reset see ready=0, except x0 requests, which are still acknowledged combinationally; their discard has no effect on state.
  - After reset deasserts, requesters must re-present any request that was not accepted.

Test Plan:
- Single request: N_REQ=2, req0 rd=5 value=0xDEADBEEF in cycle 0 -> ready0=1 in cycle 0; cycle 1 shows o_wb_valid=1, rd=5, value=0xDEADBEEF, o_pending=0x20, o_grant_id=0; cycle 2 shows o_wb_valid=0.
- Contention: req0 rd=3 and req1 rd=4 both valid from cycle 0 with valid held until accepted -> grant req0 in cycle 0 and req1 in cycle 1; writes rd=3 then rd=4 on cycles 1 and 2; next simultaneous pair grants req0 first again (pointer=1).
- x0 drop: req0 rd=0 and req1 rd=7 both valid in the same cycle -> ready0=1 and ready1=1 in that cycle; exactly one write follows (rd=7); o_pending bit 0 stays 0; pointer becomes 1.
- Fairness: N_REQ=3, all requesters continuously valid with nonzero rd for 9 cycles -> grant sequence 0,1,2,0,1,2,0,1,2; each requester gets exactly 3 writes.
- Same-rd ordering: req1 rd=9 value=1 granted, then req0 rd=9 value=2 granted next cycle -> writes appear in that order on consecutive cycles, so the final value of x9 is 2.
- Reset mid-operation: assert i_rst while o_wb_valid=1 -> o_wb_valid=0 and o_pending=0 before the next clock edge; after release, a simultaneous req0/req1 pair grants req0 first.
